pe_result_writer: RTL and testbench
===================================

Name: pe_result_writer

Overview:
Downstream stage of the PE-array controller. It captures the flattened L_RAM_SIZE x L_RAM_SIZE result bus when the controller raises done. It then writes the results one word per transfer into the shared BRAM result region using a valid/ready write port. When all words are written it reports completion, and on host ack it pulses a release strobe that re-arms the controller.

Parameters:
L_RAM_SIZE, 8, matrix dimension; must be a power of 2; results = L_RAM_SIZE*L_RAM_SIZE words
BITWIDTH, 32, word width (IEEE-754 single)
ADDR_WIDTH, 32, write address width (word-indexed, same convention as controller rdaddr)
BASE_ADDR, 128, first result word address (just after 2*L*L operand words)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pe_done  in  1  controller done level
pe_out  in  BITWIDTH*L_RAM_SIZE*L_RAM_SIZE  flattened results; element k = pe_out[(k+1)*BITWIDTH-1 : k*BITWIDTH], k = r*L_RAM_SIZE+c
wr_en  out  1  write request (valid)
wr_addr  out  ADDR_WIDTH  word address of current write
wr_data  out  BITWIDTH  data of current write
wr_ready  in  1  sink accepts; transfer = wr_en & wr_ready on a rising edge
wb_done  out  1  all results written; held until ack
ack  in  1  host acknowledge, sampled only in DONE
pe_release  out  1  one-cycle pulse to controller start after ack

Behaviour:
- Single clock, synchronous active-high reset; every register updates on posedge clk only.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wb_done=0, pe_release=0, state=IDLE, idx=0, done_q=0.
- done_q registers pe_done each cycle. Rise = pe_done & ~done_q. pe_done already high in the first cycle after reset counts as a rise.
- States: IDLE, CAPTURE, WRITE, DONE.
- IDLE: on rise, go to CAPTURE.
- CAPTURE: latch full pe_out into internal buffer (one cycle); idx=0; go to WRITE.
- WRITE:
  - wr_en=1, wr_addr=BASE_ADDR+idx, wr_data=buffer[idx]; all registered.
  - Outputs are stable while wr_ready=0.
  - On transfer: if idx==L*L-1 go to DONE with wr_en=0 next cycle; else idx+1 and next word presented next cycle.
  - Back-to-back transfers are allowed: L*L writes take L*L cycles with wr_ready tied high.
- Latency: rise to first wr_en = 2 cycles. Last transfer to wb_done = 1 cycle.
- DONE: wb_done=1. On ack=1: pe_release=1 for exactly one cycle, wb_done=0, go to IDLE.
- Boundary and ordering rules:
  - pe_done edges in CAPTURE/WRITE/DONE are ignored; the buffer is never overwritten mid-write.
  - ack outside DONE is ignored.
  - ack held high: only one pe_release pulse, because IDLE does not sample ack.
  - The controller deasserts done after pe_release. A new rise in IDLE starts a new pass.
  - Reset mid-WRITE: abandon remaining words; outputs return to reset values next edge; no partial wb_done.
  - idx width = clog2(L*L) bits; wr_addr sum truncated to ADDR_WIDTH (wrap allowed, no error).
  - Data is passed bit-exact; no arithmetic on wr_data.

Optional Feature:
Macro PE_WB_CHECKSUM_EN.
- Defined:
  - Keep a BITWIDTH-bit running sum (mod 2^BITWIDTH) of accepted wr_data words; cleared in CAPTURE.
  - After the last result word, stay in WRITE for one extra transfer: wr_addr=BASE_ADDR+L*L, wr_data=sum.
  - wb_done asserts after that transfer, so total writes = L*L+1.
- Undefined: no accumulator, exactly L*L writes, no extra logic.

Decomposition:
- Package pe_pkg: state enum (IDLE, CAPTURE, WRITE, DONE), localparam NUM_RESULTS = L_RAM_SIZE*L_RAM_SIZE, index width function.
- One natural sub-module: pe_result_buffer. It holds the capture register array, with a load strobe and an idx-to-word read mux.
- FSM, counter and write port stay in pe_result_writer.

Test Plan:
- L=2, pe_out words {k+1} for k=0..3, wr_ready=1, pe_done 0->1 -> writes (128,1),(129,2),(130,3),(131,4) on consecutive cycles; first wr_en 2 cycles after rise; wb_done one cycle after last.
- Same data with wr_ready toggling 1,0,0,1,... -> each word held stable while stalled; exactly 4 transfers, in order, no duplicates.
- In DONE hold ack=1 for 5 cycles -> single 1-cycle pe_release, wb_done drops; second pe_done rise starts a new pass at addr 128.
- Change pe_out and toggle pe_done during WRITE -> written data equals the originally captured values.
- Assert reset after 2 of 4 transfers -> wr_en=0 next cycle, wb_done never set; a fresh rise rewrites from 128.
- With PE_WB_CHECKSUM_EN, data {1,2,3,0xFFFFFFFF} -> fifth write at 132 with data 0x00000005; wb_done after it.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE result write-back slice.
// The optional checksum word is enabled with the PE_WB_CHECKSUM_EN macro.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WRITE,
    DONE
  } wb_state_t;

  localparam int DEFAULT_L_RAM_SIZE = 8;
  localparam int NUM_RESULTS        = DEFAULT_L_RAM_SIZE * DEFAULT_L_RAM_SIZE;

  // A one-word matrix still needs a 1-bit index so the counter has a legal width.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/pe_result_buffer.sv
// Capture register array for the flattened PE result bus, with a
// single-cycle load strobe and an index-selected word read mux.
module pe_result_buffer #(
  parameter int BITWIDTH  = 32,
  parameter int NUM_WORDS = 64,
  parameter int IDX_W     = 6
) (
  input  logic                          clk,
  input  logic                          load,
  input  logic [BITWIDTH*NUM_WORDS-1:0] din,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [BITWIDTH-1:0]           rd_data
);

  logic [BITWIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        mem[k] <= din[k*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Out-of-range indices only occur for the unused look-ahead past the last word.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_WORDS) begin
      rd_data = mem[rd_idx];
    end
  end

endmodule

// File: rtl/pe_result_writer.sv
// Captures the PE result matrix on a done rise and streams it word by word
// into the BRAM result region; PE_WB_CHECKSUM_EN appends a running-sum word.
module pe_result_writer
  import pe_pkg::*;
#(
  parameter int L_RAM_SIZE = DEFAULT_L_RAM_SIZE,
  parameter int BITWIDTH   = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 128
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      pe_done,
  input  logic [BITWIDTH*L_RAM_SIZE*L_RAM_SIZE-1:0] pe_out,
  output logic                                      wr_en,
  output logic [ADDR_WIDTH-1:0]                     wr_addr,
  output logic [BITWIDTH-1:0]                       wr_data,
  input  logic                                      wr_ready,
  output logic                                      wb_done,
  input  logic                                      ack,
  output logic                                      pe_release
);

  localparam int               NUM_WORDS = L_RAM_SIZE * L_RAM_SIZE;
  localparam int               IDX_W     = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

  wb_state_t state, state_next;

  logic                  done_q;
  logic                  rise;
  logic                  xfer;
  logic                  last_word;
  logic                  write_final;
  logic [IDX_W-1:0]      idx, idx_inc, idx_n;
  logic [BITWIDTH-1:0]   next_word;
  logic                  wr_en_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n;
  logic [BITWIDTH-1:0]   wr_data_n;
  logic                  wb_done_n;
  logic                  release_n;

`ifdef PE_WB_CHECKSUM_EN
  logic [BITWIDTH-1:0] sum, sum_n;
  logic                sum_phase, sum_phase_n;
`endif

  assign rise      = pe_done & ~done_q;
  assign xfer      = wr_en & wr_ready;
  assign idx_inc   = idx + IDX_W'(1);
  assign last_word = (idx == LAST_IDX);

`ifdef PE_WB_CHECKSUM_EN
  assign write_final = sum_phase;
`else
  assign write_final = last_word;
`endif

  pe_result_buffer #(
    .BITWIDTH (BITWIDTH),
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) u_buffer (
    .clk    (clk),
    .load   (state == CAPTURE),
    .din    (pe_out),
    .rd_idx (idx_inc),
    .rd_data(next_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: state_next = WRITE;
      WRITE:   if (xfer && write_final) state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word 0 is taken straight from the bus in CAPTURE because the buffer
  // loads on that same edge; later words come from the registered copy.
  always_comb begin
    wr_en_n   = wr_en;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    wb_done_n = wb_done;
    release_n = 1'b0;
    idx_n     = idx;
`ifdef PE_WB_CHECKSUM_EN
    sum_n       = sum;
    sum_phase_n = sum_phase;
`endif
    case (state)
      CAPTURE: begin
        wr_en_n   = 1'b1;
        wr_addr_n = ADDR_WIDTH'(BASE_ADDR);
        wr_data_n = pe_out[BITWIDTH-1:0];
        idx_n     = '0;
`ifdef PE_WB_CHECKSUM_EN
        sum_n       = '0;
        sum_phase_n = 1'b0;
`endif
      end
      WRITE: begin
        if (xfer) begin
`ifdef PE_WB_CHECKSUM_EN
          if (sum_phase) begin
            wr_en_n     = 1'b0;
            wb_done_n   = 1'b1;
            sum_phase_n = 1'b0;
          end else begin
            sum_n = sum + wr_data;
            if (last_word) begin
              sum_phase_n = 1'b1;
              wr_addr_n   = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(NUM_WORDS);
              wr_data_n   = sum + wr_data;
            end else begin
              idx_n     = idx_inc;
              wr_addr_n = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_inc);
              wr_data_n = next_word;
            end
          end
`else
          if (last_word) begin
            wr_en_n   = 1'b0;
            wb_done_n = 1'b1;
          end else begin
            idx_n     = idx_inc;
            wr_addr_n = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_inc);
            wr_data_n = next_word;
          end
`endif
        end
      end
      DONE: begin
        if (ack) begin
          wb_done_n = 1'b0;
          release_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q     <= 1'b0;
      idx        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wb_done    <= 1'b0;
      pe_release <= 1'b0;
    end else begin
      done_q     <= pe_done;
      idx        <= idx_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      wb_done    <= wb_done_n;
      pe_release <= release_n;
    end
  end

`ifdef PE_WB_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= '0;
      sum_phase <= 1'b0;
    end else begin
      sum       <= sum_n;
      sum_phase <= sum_phase_n;
    end
  end
`endif

endmodule

// File: tb/tb_pe_result_writer.sv
// Directed self-checking bench for pe_result_writer with a 2x2 result matrix;
// expectations adapt to PE_WB_CHECKSUM_EN (extra running-sum word at BASE+4).
module tb_pe_result_writer;

  localparam int L    = 2;
  localparam int BW   = 32;
  localparam int AW   = 32;
  localparam int BASE = 128;
  localparam int NW   = L * L;
`ifdef PE_WB_CHECKSUM_EN
  localparam int EXP_WRITES = NW + 1;
`else
  localparam int EXP_WRITES = NW;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            pe_done;
  logic [BW*NW-1:0] pe_out;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [BW-1:0]   wr_data;
  logic            wr_ready;
  logic            wb_done;
  logic            ack;
  logic            pe_release;

  int assertions = 0;
  int failures   = 0;

  logic [AW-1:0] addrLog [16];
  logic [BW-1:0] dataLog [16];
  logic [BW-1:0] curWords [NW];
  int nXfer;
  int firstEnCyc;
  int doneCyc;
  int stallErr;

  pe_result_writer #(
    .L_RAM_SIZE(L),
    .BITWIDTH  (BW),
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pe_done   (pe_done),
    .pe_out    (pe_out),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .wb_done   (wb_done),
    .ack       (ack),
    .pe_release(pe_release)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    curWords[0] = w0;
    curWords[1] = w1;
    curWords[2] = w2;
    curWords[3] = w3;
    pe_out  = {w3, w2, w1, w0};
    pe_done = 1'b1;
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,..., 2: disturb pe_out/pe_done mid-write
  task automatic collectWrites(input int mode, input int stopAfter, input int budget);
    logic          held;
    logic [AW-1:0] hA;
    logic [BW-1:0] hD;
    nXfer      = 0;
    firstEnCyc = -1;
    doneCyc    = -1;
    stallErr   = 0;
    held       = 1'b0;
    hA         = '0;
    hD         = '0;
    for (int c = 0; c < budget; c++) begin
      if (wb_done) begin
        doneCyc = c;
        return;
      end
      wr_ready = (mode == 1) ? (c % 3 == 0) : 1'b1;
      if (mode == 2 && c >= 3) begin
        pe_out  = {NW{32'hDEADBEEF}};
        pe_done = c[0];
      end
      if (wr_en && firstEnCyc < 0) firstEnCyc = c;
      if (held && (wr_addr !== hA || wr_data !== hD)) stallErr++;
      held = 1'b0;
      if (wr_en && !wr_ready) begin
        held = 1'b1;
        hA   = wr_addr;
        hD   = wr_data;
      end
      if (wr_en && wr_ready && nXfer < 16) begin
        addrLog[nXfer] = wr_addr;
        dataLog[nXfer] = wr_data;
        nXfer++;
      end
      tick();
      if (stopAfter > 0 && nXfer == stopAfter) return;
    end
    checkOutput("collect_timeout", {63'd0, wb_done}, 64'd1);
  endtask

  task automatic checkLog(input string tag);
    logic [BW-1:0] sum;
    logic [AW-1:0] ea;
    logic [BW-1:0] ed;
    sum = '0;
    checkOutput({tag, "_count"}, 64'(nXfer), 64'(EXP_WRITES));
    for (int i = 0; i < EXP_WRITES && i < nXfer; i++) begin
      if (i < NW) begin
        ea  = AW'(BASE + i);
        ed  = curWords[i];
        sum = sum + curWords[i];
      end else begin
        ea = AW'(BASE + NW);
        ed = sum;
      end
      checkOutput($sformatf("%s_w%0d", tag, i), {addrLog[i], dataLog[i]}, {ea, ed});
    end
  endtask

  task automatic releaseCheck(input string tag);
    int pulses;
    pulses = 0;
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pe_release) pulses++;
      if (i == 0) pe_done = 1'b0;
    end
    checkOutput({tag, "_release_pulses"}, 64'(pulses), 64'd1);
    checkOutput({tag, "_wb_done_cleared"}, {63'd0, wb_done}, 64'd0);
    ack = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    pe_done  = 1'b0;
    wr_ready = 1'b0;
    ack      = 1'b0;
    pe_out   = '0;
    tick();
    tick();
    checkOutput("rst_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_wb_done", {63'd0, wb_done}, 64'd0);
    checkOutput("rst_pe_release", {63'd0, pe_release}, 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] pass 1: back-to-back writes");
    applyStimulus(32'd1, 32'd2, 32'd3, 32'd4);
    collectWrites(0, 0, 40);
    checkOutput("t1_first_en_latency", 64'(firstEnCyc), 64'd2);
    checkOutput("t1_wb_done_latency", 64'(doneCyc), 64'(2 + EXP_WRITES));
    checkLog("t1");
    releaseCheck("t1");

    $display("[TB] pass 2: stalled sink, ack held");
    applyStimulus(32'd1, 32'd2, 32'd3, 32'd4);
    collectWrites(1, 0, 80);
    checkOutput("t2_stall_stable", 64'(stallErr), 64'd0);
    checkLog("t2");
    releaseCheck("t2");

    $display("[TB] pass 3: inputs disturbed during write");
    applyStimulus(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    collectWrites(2, 0, 40);
    checkLog("t3");
    releaseCheck("t3");

    $display("[TB] pass 4: reset mid-write");
    applyStimulus(32'd5, 32'd6, 32'd7, 32'd8);
    collectWrites(0, 2, 40);
    checkOutput("t4_partial_count", 64'(nXfer), 64'd2);
    reset = 1'b1;
    tick();
    checkOutput("t4_rst_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("t4_rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("t4_rst_wb_done", {63'd0, wb_done}, 64'd0);
    tick();
    checkOutput("t4_rst_wb_done_hold", {63'd0, wb_done}, 64'd0);
    reset = 1'b0;
    collectWrites(0, 0, 40);
    checkOutput("t4_first_en_after_reset", 64'(firstEnCyc), 64'd2);
    checkLog("t4");
    releaseCheck("t4");

    $display("[TB] pass 5: wrapping data words");
    applyStimulus(32'd1, 32'd2, 32'd3, 32'hFFFFFFFF);
    collectWrites(0, 0, 40);
    checkOutput("t5_wb_done_latency", 64'(doneCyc), 64'(2 + EXP_WRITES));
    checkLog("t5");
    releaseCheck("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
